// File: rtl/axi_resp_delay.sv
// AXI R/B response delay line: per-channel in-order FIFO whose entries release after a programmable latency.
// Optional `AXI_DELAY_JITTER_EN adds an LFSR-driven random extra delay per beat.
module axi_resp_delay_chan #(
  parameter int unsigned W           = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned LAT_WIDTH   = 8,
  parameter int unsigned JITTER_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [LAT_WIDTH-1:0]     i_lat,
  input  logic [W-1:0]             i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [W-1:0]             o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = LAT_WIDTH + 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]           r_mem [DEPTH];
  logic [CW-1:0]          r_cnt [DEPTH];
  logic [AW-1:0]          r_wptr;
  logic [AW-1:0]          r_rptr;
  logic [AW:0]            r_count;
  logic                   r_live;
  logic                   w_push;
  logic                   w_pop;
  logic [JITTER_BITS-1:0] w_jit;
  logic [CW-1:0]          w_load;

`ifdef AXI_DELAY_JITTER_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; advances only when a beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else if (w_push) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_jit = r_lfsr[JITTER_BITS-1:0];
`else
  assign w_jit = '0;
`endif

  assign w_load  = CW'(i_lat) + CW'(w_jit);
  assign o_ready = r_live && (r_count != FULL);
  assign o_valid = (r_count != '0) && (r_cnt[r_rptr] == '0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_valid && o_ready;
  assign w_pop   = o_valid && i_ready;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live  <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
      // Every stored counter ages each cycle, head or not, so a young entry can expire behind the head.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wptr == AW'(i))) begin
          r_cnt[i] <= w_load;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end
      end
    end
  end
endmodule

module axi_resp_delay #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned R_DEPTH     = 16,
  parameter int unsigned B_DEPTH     = 4,
  parameter int unsigned LAT_WIDTH   = 8,
  parameter int unsigned JITTER_BITS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LAT_WIDTH-1:0]         cfg_r_latency,
  input  logic [LAT_WIDTH-1:0]         cfg_b_latency,
  input  logic [ID_WIDTH-1:0]          m_axi_rid,
  input  logic [DATA_WIDTH-1:0]        m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rlast,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [ID_WIDTH-1:0]          m_axi_bid,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  output logic [ID_WIDTH-1:0]          s_axi_bid,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  output logic [$clog2(R_DEPTH):0]     r_count,
  output logic [$clog2(B_DEPTH):0]     b_count
);
  localparam int unsigned RW = ID_WIDTH + DATA_WIDTH + 3;
  localparam int unsigned BW = ID_WIDTH + 2;

  logic [RW-1:0] w_r_out;
  logic [BW-1:0] w_b_out;

  axi_resp_delay_chan #(
    .W           (RW),
    .DEPTH       (R_DEPTH),
    .LAT_WIDTH   (LAT_WIDTH),
    .JITTER_BITS (JITTER_BITS)
  ) u_r (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_lat   (cfg_r_latency),
    .i_data  ({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
    .i_valid (m_axi_rvalid),
    .o_ready (m_axi_rready),
    .o_data  (w_r_out),
    .o_valid (s_axi_rvalid),
    .i_ready (s_axi_rready),
    .o_count (r_count)
  );

  axi_resp_delay_chan #(
    .W           (BW),
    .DEPTH       (B_DEPTH),
    .LAT_WIDTH   (LAT_WIDTH),
    .JITTER_BITS (JITTER_BITS)
  ) u_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_lat   (cfg_b_latency),
    .i_data  ({m_axi_bid, m_axi_bresp}),
    .i_valid (m_axi_bvalid),
    .o_ready (m_axi_bready),
    .o_data  (w_b_out),
    .o_valid (s_axi_bvalid),
    .i_ready (s_axi_bready),
    .o_count (b_count)
  );

  assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = w_r_out;
  assign {s_axi_bid, s_axi_bresp}                           = w_b_out;
endmodule

// File: tb/tb_axi_resp_delay.sv
// Self-checking bench for axi_resp_delay: queue-based timing model checked every cycle plus directed scenarios.
module tb_axi_resp_delay;
  localparam int RD = 16;
  localparam int BD = 4;
  localparam int JB = 2;
`ifdef AXI_DELAY_JITTER_EN
  localparam int J0 = 1;
`else
  localparam int J0 = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  cfg_r_latency = '0, cfg_b_latency = '0;
  logic [7:0]  m_axi_rid = '0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0, m_axi_rvalid = 1'b0, m_axi_rready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b1;
  logic [7:0]  m_axi_bid = '0;
  logic [1:0]  m_axi_bresp = '0;
  logic        m_axi_bvalid = 1'b0, m_axi_bready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready = 1'b1;
  logic [4:0]  r_count;
  logic [2:0]  b_count;

  axi_resp_delay #(
    .DATA_WIDTH(32), .ID_WIDTH(8), .R_DEPTH(RD), .B_DEPTH(BD), .LAT_WIDTH(8), .JITTER_BITS(JB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_r_latency(cfg_r_latency), .cfg_b_latency(cfg_b_latency),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .r_count(r_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each beat becomes presentable at accept_cycle+1+latency(+jitter), but never before it is the head.
  typedef struct { logic [63:0] pl; int rdy; } ent_t;
  typedef struct { int c; logic [7:0] id; logic [31:0] d; } rec_t;
  ent_t rq[$];
  ent_t bq[$];
  rec_t rec_r[$];
  rec_t rec_b[$];
  logic live_m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_m <= 1'b0;
    else        live_m <= 1'b1;
  end

`ifdef AXI_DELAY_JITTER_EN
  logic [15:0] lf_r, lf_b;
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction
`endif

  always @(negedge clk) begin
    logic er, eb, erdy, ebrdy;
    int   j;
    ent_t e;
    if (!rst_n) begin
      rq.delete();
      bq.delete();
`ifdef AXI_DELAY_JITTER_EN
      lf_r = 16'hACE1;
      lf_b = 16'hACE1;
`endif
      chk("rst_rvalid", s_axi_rvalid, 0);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_bready", m_axi_bready, 0);
      chk("rst_rcount", r_count, 0);
      chk("rst_bcount", b_count, 0);
    end else begin
      er = 1'b0;
      if (rq.size() > 0) er = (cyc >= rq[0].rdy);
      eb = 1'b0;
      if (bq.size() > 0) eb = (cyc >= bq[0].rdy);
      erdy  = live_m && (rq.size() < RD);
      ebrdy = live_m && (bq.size() < BD);
      chk("r_valid", s_axi_rvalid, er);
      if (er) chk("r_payload", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}, rq[0].pl);
      chk("r_ready", m_axi_rready, erdy);
      chk("r_count", r_count, 64'(rq.size()));
      chk("b_valid", s_axi_bvalid, eb);
      if (eb) chk("b_payload", {s_axi_bid, s_axi_bresp}, bq[0].pl);
      chk("b_ready", m_axi_bready, ebrdy);
      chk("b_count", b_count, 64'(bq.size()));

      if (s_axi_rvalid && s_axi_rready) rec_r.push_back('{cyc, s_axi_rid, s_axi_rdata});
      if (s_axi_bvalid && s_axi_bready) rec_b.push_back('{cyc, s_axi_bid, 32'(s_axi_bresp)});

      if (er && s_axi_rready) e = rq.pop_front();
      if (eb && s_axi_bready) e = bq.pop_front();
      if (m_axi_rvalid && erdy) begin
`ifdef AXI_DELAY_JITTER_EN
        j = int'(lf_r[JB-1:0]);
        lf_r = lfsr_step(lf_r);
`else
        j = 0;
`endif
        e.pl  = 64'({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast});
        e.rdy = cyc + 1 + int'(cfg_r_latency) + j;
        rq.push_back(e);
      end
      if (m_axi_bvalid && ebrdy) begin
`ifdef AXI_DELAY_JITTER_EN
        j = int'(lf_b[JB-1:0]);
        lf_b = lfsr_step(lf_b);
`else
        j = 0;
`endif
        e.pl  = 64'({m_axi_bid, m_axi_bresp});
        e.rdy = cyc + 1 + int'(cfg_b_latency) + j;
        bq.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_r(input logic [7:0] id, input logic [31:0] d, input logic [1:0] rs,
                        input logic lst, output int acc);
    logic hs;
    hs  = 1'b0;
    acc = -1;
    m_axi_rid = id; m_axi_rdata = d; m_axi_rresp = rs; m_axi_rlast = lst; m_axi_rvalid = 1'b1;
    for (int n = 0; n < 300 && !hs; n++) begin
      @(negedge clk);
      if (m_axi_rready) begin hs = 1'b1; acc = cyc; end
      tick();
    end
    m_axi_rvalid = 1'b0;
    if (!hs) chk("r_send_timeout", 0, 1);
  endtask

  task automatic send_b(input logic [7:0] id, input logic [1:0] rs, output int acc);
    logic hs;
    hs  = 1'b0;
    acc = -1;
    m_axi_bid = id; m_axi_bresp = rs; m_axi_bvalid = 1'b1;
    for (int n = 0; n < 300 && !hs; n++) begin
      @(negedge clk);
      if (m_axi_bready) begin hs = 1'b1; acc = cyc; end
      tick();
    end
    m_axi_bvalid = 1'b0;
    if (!hs) chk("b_send_timeout", 0, 1);
  endtask

  task automatic first_valid_r(output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin c = cyc; break; end
    end
  endtask

  task automatic first_valid_b(output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin c = cyc; break; end
    end
  endtask

  initial begin
    int acc, acc_a, f;
    #2 rst_n = 1'b0;
    #1;
    chk("init_rvalid", s_axi_rvalid, 0);
    chk("init_bvalid", s_axi_bvalid, 0);
    chk("init_rcount", r_count, 0);
    chk("init_bcount", b_count, 0);
    chk("init_rready", m_axi_rready, 0);
    chk("init_bready", m_axi_bready, 0);
    #20 rst_n = 1'b1;
    tick();
    chk("rel_rready", m_axi_rready, 1);
    chk("rel_bready", m_axi_bready, 1);

    // latency 5, beat accepted in cycle 10 -> first visible in cycle 16
    cfg_r_latency = 8'd5;
    while (cyc < 10) tick();
    send_r(8'h5A, 32'hDEADBEEF, 2'b00, 1'b1, acc);
    chk("lat5_accept_cycle", acc, 10);
    first_valid_r(f);
    chk("lat5_first_valid", f, 16 + J0);
    chk("lat5_rid", s_axi_rid, 8'h5A);
    chk("lat5_rdata", s_axi_rdata, 32'hDEADBEEF);
    chk("lat5_rlast", s_axi_rlast, 1);

    // B latency 0 -> visible the next cycle
    tick();
    cfg_b_latency = 8'd0;
    send_b(8'h33, 2'b10, acc);
    first_valid_b(f);
    chk("blat0_first_valid", f, acc + 1 + J0);
    chk("blat0_bid", s_axi_bid, 8'h33);
    chk("blat0_bresp", s_axi_bresp, 2'b10);

    // young expired beat waits behind a long-latency head
    tick();
    rec_r.delete();
    cfg_r_latency = 8'd20;
    send_r(8'h01, 32'hAAAA0001, 2'b00, 1'b1, acc_a);
    cfg_r_latency = 8'd0;
    send_r(8'h02, 32'hBBBB0002, 2'b00, 1'b1, acc);
    repeat (40) tick();
    chk("order_count", rec_r.size(), 2);
    if (rec_r.size() == 2) begin
      chk("order_first", rec_r[0].d, 32'hAAAA0001);
      chk("order_second", rec_r[1].d, 32'hBBBB0002);
      chk("order_b_after_a", rec_r[1].c > rec_r[0].c, 1);
`ifndef AXI_DELAY_JITTER_EN
      chk("order_a_cycle", rec_r[0].c, acc_a + 21);
      chk("order_b_cycle", rec_r[1].c, rec_r[0].c + 1);
`endif
    end

    // fill: 20 beats into a 16-deep buffer with the consumer stalled
    cfg_r_latency = 8'd0;
    s_axi_rready  = 1'b0;
    rec_r.delete();
    tick();
    fork
      begin
        int a;
        for (int k = 0; k < 20; k++) send_r(8'(k), 32'h1000 + k, 2'b01, k == 19, a);
      end
      begin
        int n;
        n = 0;
        while (r_count != 5'd16 && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("fill_rready_low", m_axi_rready, 0);
        chk("fill_count16", r_count, 16);
        tick();
        s_axi_rready = 1'b1;
      end
    join
    repeat (40) tick();
    chk("fill_drained", rec_r.size(), 20);
    for (int k = 0; k < 20 && k < rec_r.size(); k++) begin
      chk("fill_order_data", rec_r[k].d, 32'h1000 + k);
      chk("fill_order_id", rec_r[k].id, 8'(k));
    end

    // reset with beats buffered and heads already valid
    cfg_r_latency = 8'd10;
    s_axi_rready  = 1'b0;
    s_axi_bready  = 1'b0;
    for (int k = 0; k < 8; k++) send_r(8'(k + 8'h40), 32'h2000 + k, 2'b00, 1'b0, acc);
    for (int k = 0; k < 2; k++) send_b(8'(k + 8'h70), 2'b01, acc);
    repeat (15) tick();
    chk("pre_rst_rcount", r_count, 8);
    chk("pre_rst_rvalid", s_axi_rvalid, 1);
    chk("pre_rst_bcount", b_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", s_axi_rvalid, 0);
    chk("mid_rst_bvalid", s_axi_bvalid, 0);
    chk("mid_rst_rcount", r_count, 0);
    chk("mid_rst_bcount", b_count, 0);
    chk("mid_rst_rready", m_axi_rready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_before_edge_rready", m_axi_rready, 0);
    tick();
    chk("rel2_rready", m_axi_rready, 1);
    chk("rel2_bready", m_axi_bready, 1);
    s_axi_rready = 1'b1;
    s_axi_bready = 1'b1;
    repeat (20) tick();
    chk("post_rst_rvalid", s_axi_rvalid, 0);
    chk("post_rst_bvalid", s_axi_bvalid, 0);

`ifdef AXI_DELAY_JITTER_EN
    cfg_r_latency = 8'd4;
    for (int k = 0; k < 100; k++) begin
      send_r(8'(k), 32'h3000 + k, 2'b00, 1'b1, acc);
      first_valid_r(f);
      chk("jitter_delay_range", (f - acc >= 5) && (f - acc <= 8), 1);
      repeat (3) tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
